// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package   : mips_pipe_pkg
// Purpose   : Shared types and default widths for the MEM->WB pipeline slice.
// Revision  : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 4;
  localparam int DEF_CNT_W  = 16;

  // One MEM->WB beat at the default widths, MSB first.
  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic [DEF_DATA_W-1:0] memdata;
    logic [DEF_DATA_W-1:0] aluresult;
    logic [DEF_REG_AW-1:0] regdst;
  } wb_payload_t;

  // Write-back source select, encoded the same way as memtoreg.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_sel_e;

  // Flattened payload width for a given data / register-address width.
  function automatic int payload_w(input int data_w, input int reg_aw);
    return 2 + (2 * data_w) + reg_aw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_wb_pipe_reg_if
// Purpose   : MEM-side beat, WB-side head, forwarding tap and stall counter of
//             the MEM->WB pipeline register. master = driver side,
//             slave = pipeline register side.
// Revision  : 1.0 - initial release
// ============================================================================
interface mem_wb_pipe_reg_if #(
  parameter int DATA_W = mips_pipe_pkg::DEF_DATA_W,
  parameter int REG_AW = mips_pipe_pkg::DEF_REG_AW,
  parameter int CNT_W  = mips_pipe_pkg::DEF_CNT_W
);

  // MEM-stage side
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              regwrite;
  logic              memtoreg;
  logic [DATA_W-1:0] memdata;
  logic [DATA_W-1:0] aluresult;
  logic [REG_AW-1:0] regdst;

  // WB-stage side
  logic              out_valid;
  logic              out_ready;
  logic              regwriteout;
  logic              memtoregout;
  logic [DATA_W-1:0] memdataout;
  logic [DATA_W-1:0] aluresultout;
  logic [REG_AW-1:0] regdstout;
  logic [DATA_W-1:0] wb_data;
  logic              wb_en;

  // Forwarding tap and statistics
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_regdst;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush, in_valid, regwrite, memtoreg, memdata, aluresult, regdst,
    output out_ready,
    input  in_ready,
    input  out_valid, regwriteout, memtoregout, memdataout, aluresultout,
    input  regdstout, wb_data, wb_en,
    input  fwd_valid, fwd_regdst, fwd_data, stall_cnt
  );

  modport slave (
    input  flush, in_valid, regwrite, memtoreg, memdata, aluresult, regdst,
    input  out_ready,
    output in_ready,
    output out_valid, regwriteout, memtoregout, memdataout, aluresultout,
    output regdstout, wb_data, wb_en,
    output fwd_valid, fwd_regdst, fwd_data, stall_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module    : pipe_skid_buf
// Purpose   : Generic 2-entry valid/ready skid buffer with synchronous flush.
//             in_ready is a flop output, so there is no combinational path
//             from out_ready back to in_ready.
// Revision  : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         flush,
  input  wire logic         in_valid,
  output logic              in_ready,
  input  wire logic [W-1:0] in_data,
  output logic              out_valid,
  input  wire logic         out_ready,
  output logic [W-1:0]      out_data
);

  // State encodes {skid_v, main_v}; 2'b10 is unreachable and recovers to EMPTY.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         retire;

  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;

  // Next state and payload movement; flush wins over every transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && retire) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (retire) begin
            // Head payload is kept so the outputs hold while invalid.
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (retire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and payload registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module    : mem_wb_pipe_reg
// Purpose   : MEM->WB pipeline register. Buffers beats in a 2-entry skid
//             buffer and derives the write-back mux, zero-register guard,
//             forwarding tap and a saturating stall counter from the head.
// Revision  : 1.0 - initial release
// ============================================================================
module mem_wb_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int REG_AW         = DEF_REG_AW,
  parameter int ZERO_REG_GUARD = 1,
  parameter int CNT_W          = DEF_CNT_W
) (
  input wire logic          clk,
  input wire logic          rst_n,
  mem_wb_pipe_reg_if.slave  bus
);

  localparam int PAYLOAD_W = payload_w(DATA_W, REG_AW);

  logic [PAYLOAD_W-1:0] payload_in;
  logic [PAYLOAD_W-1:0] payload_out;
  logic                 head_valid;
  wb_sel_e              wb_sel;
  logic [DATA_W-1:0]    wb_data_mux;
  logic                 dst_is_zero;
  logic                 write_ok;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  assign payload_in = {bus.regwrite, bus.memtoreg, bus.memdata,
                       bus.aluresult, bus.regdst};

  pipe_skid_buf #(
    .W (PAYLOAD_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (payload_in),
    .out_valid (head_valid),
    .out_ready (bus.out_ready),
    .out_data  (payload_out)
  );

  assign bus.out_valid = head_valid;
  assign {bus.regwriteout, bus.memtoregout, bus.memdataout,
          bus.aluresultout, bus.regdstout} = payload_out;

  assign wb_sel = wb_sel_e'(bus.memtoregout);

  // Write-back data select from the registered head fields.
  always_comb begin
    wb_data_mux = bus.aluresultout;
    if (wb_sel == WB_MEM) begin
      wb_data_mux = bus.memdataout;
    end
  end

  // Register 0 is hard-wired; its writes are optionally suppressed.
  if (ZERO_REG_GUARD != 0) begin : g_zero_guard
    assign dst_is_zero = (bus.regdstout == '0);
  end else begin : g_no_guard
    assign dst_is_zero = 1'b0;
  end

  assign write_ok       = bus.regwriteout & ~dst_is_zero;
  assign bus.wb_data    = wb_data_mux;
  assign bus.wb_en      = head_valid & bus.out_ready & write_ok;
  assign bus.fwd_valid  = head_valid & write_ok;
  assign bus.fwd_regdst = bus.regdstout;
  assign bus.fwd_data   = wb_data_mux;

  // Count cycles the head is held back by the register file, saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (head_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module    : tb_mem_wb_pipe_reg
// Purpose   : Scoreboard bench for mem_wb_pipe_reg: directed beats are pushed
//             into an expectation queue on acceptance and a monitor compares
//             every retired head beat against it.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe_reg;
  import mips_pipe_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  wb_payload_t exp_q[$];

  mem_wb_pipe_reg_if #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) mw ();
  mem_wb_pipe_reg_if #(.DATA_W(16), .REG_AW(4), .CNT_W(4))  sw ();

  mem_wb_pipe_reg #(
    .DATA_W(16), .REG_AW(4), .ZERO_REG_GUARD(1), .CNT_W(16)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mw.slave)
  );

  mem_wb_pipe_reg #(
    .DATA_W(16), .REG_AW(4), .ZERO_REG_GUARD(1), .CNT_W(4)
  ) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Offer one beat until accepted (bounded); push its expectation on accept.
  task automatic send(input logic rw, input logic mtr, input logic [15:0] md,
                      input logic [15:0] alu, input logic [3:0] rd);
    logic        acc;
    logic        done;
    wb_payload_t p;
    p.regwrite  = rw;
    p.memtoreg  = mtr;
    p.memdata   = md;
    p.aluresult = alu;
    p.regdst    = rd;
    mw.regwrite  = rw;
    mw.memtoreg  = mtr;
    mw.memdata   = md;
    mw.aluresult = alu;
    mw.regdst    = rd;
    mw.in_valid  = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = mw.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back(p);
        done = 1'b1;
        break;
      end
    end
    chk("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic idle();
    mw.in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected beat has been retired.
  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compare each retired head beat with the oldest expectation.
  initial begin : monitor
    wb_payload_t e;
    logic [15:0] m_wb_data;
    logic        m_write_ok;
    forever begin
      @(negedge clk);
      if (rst_n && mw.out_valid && mw.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_beat: got regdst %0d, want no beat", mw.regdstout);
        end else begin
          e          = exp_q.pop_front();
          m_wb_data  = e.memtoreg ? e.memdata : e.aluresult;
          m_write_ok = e.regwrite && (e.regdst != 4'd0);
          chk("mon_regdstout",    32'(mw.regdstout),    32'(e.regdst));
          chk("mon_aluresultout", 32'(mw.aluresultout), 32'(e.aluresult));
          chk("mon_memdataout",   32'(mw.memdataout),   32'(e.memdata));
          chk("mon_regwriteout",  32'(mw.regwriteout),  32'(e.regwrite));
          chk("mon_memtoregout",  32'(mw.memtoregout),  32'(e.memtoreg));
          chk("mon_wb_data",      32'(mw.wb_data),      32'(m_wb_data));
          chk("mon_wb_en",        32'(mw.wb_en),        32'(m_write_ok));
          chk("mon_fwd_valid",    32'(mw.fwd_valid),    32'(m_write_ok));
          chk("mon_fwd_regdst",   32'(mw.fwd_regdst),   32'(e.regdst));
          chk("mon_fwd_data",     32'(mw.fwd_data),     32'(m_wb_data));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n        = 1'b0;
    mw.flush     = 1'b0;
    mw.in_valid  = 1'b0;
    mw.regwrite  = 1'b0;
    mw.memtoreg  = 1'b0;
    mw.memdata   = 16'h0;
    mw.aluresult = 16'h0;
    mw.regdst    = 4'h0;
    mw.out_ready = 1'b0;
    sw.flush     = 1'b0;
    sw.in_valid  = 1'b0;
    sw.regwrite  = 1'b1;
    sw.memtoreg  = 1'b0;
    sw.memdata   = 16'h0;
    sw.aluresult = 16'h00C3;
    sw.regdst    = 4'h2;
    sw.out_ready = 1'b0;

    // Reset values before any clock edge
    #2;
    chk("rst_out_valid", 32'(mw.out_valid), 32'd0);
    chk("rst_in_ready",  32'(mw.in_ready),  32'd1);
    chk("rst_regdstout", 32'(mw.regdstout), 32'd0);
    chk("rst_stall_cnt", 32'(mw.stall_cnt), 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset asserted mid-cycle with a stalled beat held
    send(1'b1, 1'b0, 16'h0000, 16'h0077, 4'd7);
    idle();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", 32'(mw.out_valid), 32'd1);
    chk("pre_rst_stall_cnt", 32'(mw.stall_cnt), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(mw.out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(mw.in_ready),  32'd1);
    chk("mid_rst_regdstout", 32'(mw.regdstout), 32'd0);
    chk("mid_rst_stall_cnt", 32'(mw.stall_cnt), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming with out_ready held high
    mw.out_ready = 1'b1;
    send(1'b1, 1'b0, 16'h0000, 16'h0011, 4'd1);
    chk("stream_latency_valid",  32'(mw.out_valid), 32'd1);
    chk("stream_latency_regdst", 32'(mw.regdstout), 32'd1);
    chk("stream_latency_wb_en",  32'(mw.wb_en),     32'd1);
    for (int i = 2; i <= 5; i++) begin
      send(1'b1, 1'b0, 16'h0000, 16'(i * 16'h11), 4'(i));
    end
    idle();
    drain();

    // Backpressure: fill to FULL, third beat waits at the source
    mw.out_ready = 1'b0;
    fork
      begin
        send(1'b1, 1'b0, 16'h0000, 16'h00A0, 4'hA);
        send(1'b1, 1'b0, 16'h0000, 16'h00B0, 4'hB);
        send(1'b1, 1'b0, 16'h0000, 16'h00C0, 4'hC);
        idle();
      end
      begin : bp_checks
        int k;
        for (k = 0; k < 20; k++) begin
          @(negedge clk);
          if (!mw.in_ready) break;
        end
        chk("bp_full_seen",     32'(k < 20),        32'd1);
        chk("bp_in_ready",      32'(mw.in_ready),   32'd0);
        chk("bp_out_valid",     32'(mw.out_valid),  32'd1);
        chk("bp_head_is_a",     32'(mw.regdstout),  32'hA);
        chk("bp_stall_cnt_1",   32'(mw.stall_cnt),  32'd1);
        @(negedge clk);
        chk("bp_stall_cnt_2",   32'(mw.stall_cnt),  32'd2);
        @(negedge clk);
        chk("bp_stall_cnt_3",   32'(mw.stall_cnt),  32'd3);
        @(posedge clk);
        #1;
        mw.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_stall_cnt_final", 32'(mw.stall_cnt), 32'd4);

    // Write-back mux and zero-register guard
    send(1'b1, 1'b1, 16'hBEEF, 16'h1234, 4'd3);
    chk("mux_wb_data",   32'(mw.wb_data),   32'hBEEF);
    chk("mux_wb_en",     32'(mw.wb_en),     32'd1);
    chk("mux_fwd_valid", 32'(mw.fwd_valid), 32'd1);
    send(1'b1, 1'b1, 16'hBEEF, 16'h1234, 4'd0);
    chk("guard_wb_data",   32'(mw.wb_data),   32'hBEEF);
    chk("guard_wb_en",     32'(mw.wb_en),     32'd0);
    chk("guard_fwd_valid", 32'(mw.fwd_valid), 32'd0);
    send(1'b0, 1'b0, 16'h0000, 16'hABCD, 4'd5);
    chk("nowrite_wb_data", 32'(mw.wb_data), 32'hABCD);
    chk("nowrite_wb_en",   32'(mw.wb_en),   32'd0);
    idle();
    drain();

    // Flush while FULL with a beat offered
    mw.out_ready = 1'b0;
    send(1'b1, 1'b0, 16'h0000, 16'h00D0, 4'd8);
    send(1'b1, 1'b0, 16'h0000, 16'h00E0, 4'd9);
    chk("fl_full_in_ready", 32'(mw.in_ready), 32'd0);
    mw.regdst    = 4'hF;
    mw.aluresult = 16'h00F0;
    mw.in_valid  = 1'b1;
    mw.flush     = 1'b1;
    @(posedge clk);
    #1;
    mw.flush    = 1'b0;
    mw.in_valid = 1'b0;
    exp_q.delete();
    chk("fl_out_valid",    32'(mw.out_valid),    32'd0);
    chk("fl_in_ready",     32'(mw.in_ready),     32'd1);
    chk("fl_regdstout",    32'(mw.regdstout),    32'd0);
    chk("fl_aluresultout", 32'(mw.aluresultout), 32'd0);
    chk("fl_wb_data",      32'(mw.wb_data),      32'd0);

    // Flush in ONE while a beat is accepted in the same cycle
    send(1'b1, 1'b0, 16'h0000, 16'h0066, 4'd6);
    mw.regdst    = 4'd4;
    mw.aluresult = 16'h0044;
    mw.in_valid  = 1'b1;
    mw.flush     = 1'b1;
    @(posedge clk);
    #1;
    mw.flush    = 1'b0;
    mw.in_valid = 1'b0;
    exp_q.delete();
    chk("fl1_out_valid", 32'(mw.out_valid), 32'd0);
    chk("fl1_in_ready",  32'(mw.in_ready),  32'd1);
    mw.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("fl_no_ghost", 32'(mw.out_valid), 32'd0);
    send(1'b1, 1'b1, 16'h5A5A, 16'h0000, 4'd6);
    idle();
    drain();

    // Stall counter saturation on the 4-bit instance
    sw.in_valid = 1'b1;
    @(posedge clk);
    #1;
    sw.in_valid = 1'b0;
    chk("sat_out_valid", 32'(sw.out_valid), 32'd1);
    chk("sat_cnt_0",     32'(sw.stall_cnt), 32'd0);
    repeat (14) @(posedge clk);
    #1;
    chk("sat_cnt_14", 32'(sw.stall_cnt), 32'd14);
    repeat (6) @(posedge clk);
    #1;
    chk("sat_cnt_15", 32'(sw.stall_cnt), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
